// File: rtl/lower_layer_merge_n_pkg.sv
// Shared types and helpers for the lower-layer merge stage of the KNN merge-sort tree.
package lower_layer_pkg;

    typedef enum logic [1:0] {IDLE, MERGE, FIN} merge_state_t;

    // Bit width needed to hold values below 'value', never narrower than one bit.
    function automatic int clog2_safe(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lower_layer_merge_n_if.sv
// Load/stream bundle of the merge stage. Optional macro SORTED_SRC_EN adds sorted_src.
// Handshake: an element transfers on every cycle where update && out_ready.
interface lower_layer_merge_n_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RUN_LEN    = 2
);
    import lower_layer_pkg::*;

    logic                          load;
    logic                          descend;
    logic [RUN_LEN*DATA_WIDTH-1:0] data_a;
    logic [RUN_LEN*DATA_WIDTH-1:0] data_b;
    logic                          out_ready;
    logic                          busy;
    logic                          update;
    logic [DATA_WIDTH-1:0]         sorted_data;
    logic                          done;
    merge_state_t                  dbg_state;
`ifdef SORTED_SRC_EN
    localparam int SRC_W = clog2_safe(2 * RUN_LEN);
    logic [SRC_W-1:0]              sorted_src;
`endif

    modport master (
        output load, descend, data_a, data_b, out_ready,
        input  busy, update, sorted_data, done, dbg_state
`ifdef SORTED_SRC_EN
        , input sorted_src
`endif
    );

    modport slave (
        input  load, descend, data_a, data_b, out_ready,
        output busy, update, sorted_data, done, dbg_state
`ifdef SORTED_SRC_EN
        , output sorted_src
`endif
    );

endinterface

// File: rtl/lower_layer_merge_n_cmp_sel.sv
// Head-of-run selector: exhaustion checks, unsigned compare and the A-wins-ties rule.
module merge_cmp_sel #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic                  descend,
    output logic                  take_a
);

    always_comb begin
        take_a = 1'b0;
        if (a_empty) begin
            take_a = 1'b0;
        end else if (b_empty) begin
            take_a = 1'b1;
        end else if (descend) begin
            take_a = (a >= b);
        end else begin
            take_a = (a <= b);
        end
    end

endmodule

// File: rtl/lower_layer_merge_n.sv
// Two-run merge stage: load both sorted runs at once, stream the merge out with backpressure.
// Optional macro SORTED_SRC_EN adds the sorted_src origin-index output.
module lower_layer_merge_n
    import lower_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RUN_LEN    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lower_layer_merge_n_if.slave  bus
);

    localparam int PTR_W = clog2_safe(RUN_LEN + 1);
    localparam int CNT_W = clog2_safe(2 * RUN_LEN + 1);
    localparam int RUN_W = RUN_LEN * DATA_WIDTH;
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * RUN_LEN - 1);

    merge_state_t          r_state;
    merge_state_t          w_next_state;
    logic [RUN_W-1:0]      r_run_a;
    logic [RUN_W-1:0]      r_run_b;
    logic [PTR_W-1:0]      r_ptr_a;
    logic [PTR_W-1:0]      r_ptr_b;
    logic                  r_descend;
    logic [DATA_WIDTH-1:0] w_head_a;
    logic [DATA_WIDTH-1:0] w_head_b;
    logic                  w_a_empty;
    logic                  w_b_empty;
    logic                  w_take_a;
    logic                  w_update;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_accept_load;

    // An exhausted run's pointer equals RUN_LEN and has no element; its head reads 0.
    always_comb begin
        w_head_a = '0;
        w_head_b = '0;
        for (int i = 0; i < RUN_LEN; i++) begin
            if (r_ptr_a == PTR_W'(i)) w_head_a = r_run_a[i*DATA_WIDTH +: DATA_WIDTH];
            if (r_ptr_b == PTR_W'(i)) w_head_b = r_run_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_a_empty = (r_ptr_a == PTR_END);
    assign w_b_empty = (r_ptr_b == PTR_END);

    merge_cmp_sel #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_sel (
        .a       (w_head_a),
        .b       (w_head_b),
        .a_empty (w_a_empty),
        .b_empty (w_b_empty),
        .descend (r_descend),
        .take_a  (w_take_a)
    );

    assign w_update = (r_state == MERGE);
    assign w_xfer   = w_update && bus.out_ready;
    assign w_last   = ((CNT_W'(r_ptr_a) + CNT_W'(r_ptr_b)) == CNT_LAST);

    always_comb begin
        w_next_state  = r_state;
        w_accept_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_accept_load = 1'b1;
                    w_next_state  = MERGE;
                end
            end
            MERGE: begin
                if (w_xfer && w_last) w_next_state = FIN;
            end
            FIN: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_run_a   <= '0;
            r_run_b   <= '0;
            r_ptr_a   <= '0;
            r_ptr_b   <= '0;
            r_descend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept_load) begin
                r_run_a   <= bus.data_a;
                r_run_b   <= bus.data_b;
                r_ptr_a   <= '0;
                r_ptr_b   <= '0;
                r_descend <= bus.descend;
            end else if (w_xfer) begin
                if (w_take_a) r_ptr_a <= r_ptr_a + PTR_W'(1);
                else          r_ptr_b <= r_ptr_b + PTR_W'(1);
            end
        end
    end

    assign bus.update      = w_update;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == FIN);
    assign bus.dbg_state   = r_state;
    assign bus.sorted_data = w_update ? (w_take_a ? w_head_a : w_head_b) : '0;

`ifdef SORTED_SRC_EN
    localparam int SRC_W = clog2_safe(2 * RUN_LEN);
    // B elements are numbered after all of A so KNN can map back to the neighbour label.
    assign bus.sorted_src = !w_update ? '0 :
                            w_take_a  ? SRC_W'(r_ptr_a) :
                                        SRC_W'(RUN_LEN) + SRC_W'(r_ptr_b);
`endif

endmodule

// File: tb/tb_lower_layer_merge_n.sv
// Bench for lower_layer_merge_n: RUN_LEN=2 and RUN_LEN=4 instances against a list-merge model.
`timescale 1ns/1ps
module tb_lower_layer_merge_n;
    import lower_layer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    lower_layer_merge_n_if #(.DATA_WIDTH(8), .RUN_LEN(2)) bus2 ();
    lower_layer_merge_n_if #(.DATA_WIDTH(8), .RUN_LEN(4)) bus4 ();

    lower_layer_merge_n #(.DATA_WIDTH(8), .RUN_LEN(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    lower_layer_merge_n #(.DATA_WIDTH(8), .RUN_LEN(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp2_q[$];
    int         exps2_q[$];
    logic [7:0] seen2_q[$];
    int         seens2_q[$];
    logic [7:0] exp4_q[$];
    int         exps4_q[$];
    logic [7:0] seen4_q[$];
    int         seens4_q[$];

    bit         done2_flag = 0, done4_flag = 0;
    int         done2_cyc = 0, done4_cyc = 0, first2_cyc = -1, load2_cyc = 0;
    bit         prev2_stall = 0, prev4_stall = 0, prev2_done = 0, prev4_done = 0;
    logic [7:0] prev2_data = 0, prev4_data = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain two-list merge: take the smaller (larger when descending) head, A on ties.
    task automatic model_merge(input int a[4], input int b[4], input int n, input bit desc,
                               output int v[8], output int s[8]);
        int  ia, ib;
        bit  pick_a;
        ia = 0;
        ib = 0;
        v  = '{default: 0};
        s  = '{default: 0};
        for (int k = 0; k < 2 * n; k++) begin
            if (ia == n)      pick_a = 0;
            else if (ib == n) pick_a = 1;
            else              pick_a = desc ? (a[ia] >= b[ib]) : (a[ia] <= b[ib]);
            if (pick_a) begin v[k] = a[ia]; s[k] = ia;     ia++; end
            else        begin v[k] = b[ib]; s[k] = n + ib; ib++; end
        end
    endtask

    // ---------------- compare processes ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus2.update) begin
                chk("busy2_with_update", bus2.busy, 1);
                if (first2_cyc < 0) first2_cyc = cyc;
                if (prev2_stall) chk("hold2_data", bus2.sorted_data, prev2_data);
                if (bus2.out_ready) begin
                    chk("xfer2_expected", exp2_q.size() > 0, 1);
                    if (exp2_q.size() > 0) begin
                        chk("data2", bus2.sorted_data, exp2_q.pop_front());
`ifdef SORTED_SRC_EN
                        chk("src2", bus2.sorted_src, exps2_q.pop_front());
                        seens2_q.push_back(int'(bus2.sorted_src));
`else
                        void'(exps2_q.pop_front());
`endif
                        seen2_q.push_back(bus2.sorted_data);
                    end
                end
            end else begin
                chk("idle2_data_zero", bus2.sorted_data, 0);
`ifdef SORTED_SRC_EN
                chk("idle2_src_zero", bus2.sorted_src, 0);
`endif
            end
            if (bus2.done) begin
                chk("done2_after_last", exp2_q.size(), 0);
                chk("done2_single", prev2_done, 0);
                done2_flag = 1;
                done2_cyc  = cyc;
            end
            prev2_done  = bus2.done;
            prev2_stall = bus2.update && !bus2.out_ready;
            prev2_data  = bus2.sorted_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus4.update) begin
                chk("busy4_with_update", bus4.busy, 1);
                if (prev4_stall) chk("hold4_data", bus4.sorted_data, prev4_data);
                if (bus4.out_ready) begin
                    chk("xfer4_expected", exp4_q.size() > 0, 1);
                    if (exp4_q.size() > 0) begin
                        chk("data4", bus4.sorted_data, exp4_q.pop_front());
`ifdef SORTED_SRC_EN
                        chk("src4", bus4.sorted_src, exps4_q.pop_front());
                        seens4_q.push_back(int'(bus4.sorted_src));
`else
                        void'(exps4_q.pop_front());
`endif
                        seen4_q.push_back(bus4.sorted_data);
                    end
                end
            end else begin
                chk("idle4_data_zero", bus4.sorted_data, 0);
            end
            if (bus4.done) begin
                chk("done4_after_last", exp4_q.size(), 0);
                chk("done4_single", prev4_done, 0);
                done4_flag = 1;
                done4_cyc  = cyc;
            end
            prev4_done  = bus4.done;
            prev4_stall = bus4.update && !bus4.out_ready;
            prev4_data  = bus4.sorted_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start2();
        seen2_q.delete();
        seens2_q.delete();
        done2_flag = 0;
        first2_cyc = -1;
    endtask

    task automatic start4();
        seen4_q.delete();
        seens4_q.delete();
        done4_flag = 0;
    endtask

    task automatic load2(input int a0, input int a1, input int b0, input int b1,
                         input bit desc, input bit expect_accept);
        int a[4], b[4], v[8], s[8];
        a = '{a0, a1, 0, 0};
        b = '{b0, b1, 0, 0};
        if (expect_accept) begin
            model_merge(a, b, 2, desc, v, s);
            for (int k = 0; k < 4; k++) begin
                exp2_q.push_back(v[k][7:0]);
                exps2_q.push_back(s[k]);
            end
            load2_cyc = cyc;
        end
        bus2.data_a  = {a1[7:0], a0[7:0]};
        bus2.data_b  = {b1[7:0], b0[7:0]};
        bus2.descend = desc;
        bus2.load    = 1'b1;
        @(posedge clk); #1;
        bus2.load    = 1'b0;
    endtask

    task automatic load4(input int a[4], input int b[4], input bit desc);
        int v[8], s[8];
        model_merge(a, b, 4, desc, v, s);
        for (int k = 0; k < 8; k++) begin
            exp4_q.push_back(v[k][7:0]);
            exps4_q.push_back(s[k]);
        end
        for (int i = 0; i < 4; i++) begin
            bus4.data_a[i*8 +: 8] = a[i][7:0];
            bus4.data_b[i*8 +: 8] = b[i][7:0];
        end
        bus4.descend = desc;
        bus4.load    = 1'b1;
        @(posedge clk); #1;
        bus4.load    = 1'b0;
    endtask

    task automatic wait_done2(input int budget, input bit bp);
        for (int i = 0; i < budget && !done2_flag; i++) begin
            @(posedge clk); #1;
            if (bp) bus2.out_ready = ~bus2.out_ready;
        end
        chk("done2_seen", done2_flag, 1);
        bus2.out_ready = 1'b1;
    endtask

    task automatic wait_done4(input int budget);
        for (int i = 0; i < budget && !done4_flag; i++) begin
            @(posedge clk); #1;
        end
        chk("done4_seen", done4_flag, 1);
    endtask

    task automatic chk_seq2(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_len"}, seen2_q.size(), 4);
        for (int k = 0; k < 4; k++)
            chk(name, (k < seen2_q.size()) ? 32'(seen2_q[k]) : 32'hFFFF_FFFF, e[k]);
    endtask

    task automatic chk_seq4(input string name, input int e[8]);
        chk({name, "_len"}, seen4_q.size(), 8);
        for (int k = 0; k < 8; k++)
            chk(name, (k < seen4_q.size()) ? 32'(seen4_q[k]) : 32'hFFFF_FFFF, e[k]);
    endtask

`ifdef SORTED_SRC_EN
    task automatic chk_src2(input string name, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++)
            chk(name, (k < seens2_q.size()) ? seens2_q[k] : -1, e[k]);
    endtask

    task automatic chk_src4(input string name, input int e[8]);
        for (int k = 0; k < 8; k++)
            chk(name, (k < seens4_q.size()) ? seens4_q[k] : -1, e[k]);
    endtask
`endif

    // ---------------- directed sequence ----------------
    initial begin
        int a4[4], b4[4], e4[8];
        bus2.load = 0; bus2.descend = 0; bus2.data_a = '0; bus2.data_b = '0; bus2.out_ready = 1;
        bus4.load = 0; bus4.descend = 0; bus4.data_a = '0; bus4.data_b = '0; bus4.out_ready = 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst2_busy",   bus2.busy, 0);
        chk("rst2_update", bus2.update, 0);
        chk("rst2_done",   bus2.done, 0);
        chk("rst2_data",   bus2.sorted_data, 0);
        chk("rst2_state",  bus2.dbg_state, IDLE);
        chk("rst4_update", bus4.update, 0);

        // Ascending merge with no stalls: latency 1, done five cycles after load.
        start2();
        load2(3, 9, 5, 7, 0, 1);
        wait_done2(20, 0);
        chk_seq2("t1_seq", 3, 5, 7, 9);
        chk("t1_first_lat", first2_cyc - load2_cyc, 1);
        chk("t1_done_lat",  done2_cyc - load2_cyc, 5);
        chk("t1_idle_busy", bus2.busy, 0);

        // Descending, RUN_LEN=4.
        start4();
        a4 = '{40, 30, 20, 10};
        b4 = '{35, 25, 15, 5};
        load4(a4, b4, 1);
        wait_done4(30);
        e4 = '{40, 35, 30, 25, 20, 15, 10, 5};
        chk_seq4("t2_seq", e4);
`ifdef SORTED_SRC_EN
        e4 = '{0, 4, 1, 5, 2, 6, 3, 7};
        chk_src4("t2_src", e4);
`endif

        // All-equal ties: A drains first.
        start2();
        load2(4, 4, 4, 4, 0, 1);
        wait_done2(20, 0);
        chk_seq2("t3_seq", 4, 4, 4, 4);
`ifdef SORTED_SRC_EN
        chk_src2("t3_src", 0, 1, 2, 3);
`endif

        // Descending with mixed ties, RUN_LEN=4.
        start4();
        a4 = '{9, 7, 7, 1};
        b4 = '{9, 7, 2, 1};
        load4(a4, b4, 1);
        wait_done4(30);
        e4 = '{9, 9, 7, 7, 7, 2, 1, 1};
        chk_seq4("t3b_seq", e4);
`ifdef SORTED_SRC_EN
        e4 = '{0, 4, 1, 2, 5, 6, 3, 7};
        chk_src4("t3b_src", e4);
`endif

        // Backpressure: out_ready toggles every cycle.
        start2();
        load2(3, 9, 5, 7, 0, 1);
        wait_done2(40, 1);
        chk_seq2("t4_seq", 3, 5, 7, 9);

        // Load while merging is ignored.
        start2();
        load2(3, 9, 5, 7, 0, 1);
        @(posedge clk); #1;
        load2(1, 2, 0, 6, 1, 0);
        wait_done2(20, 0);
        chk_seq2("t5_seq", 3, 5, 7, 9);

        // Reset after the second transfer abandons the stream.
        start2();
        load2(3, 9, 5, 7, 0, 1);
        for (int i = 0; i < 20 && seen2_q.size() < 2; i++) @(posedge clk);
        #1;
        chk("t6_two_xfers", seen2_q.size(), 2);
        rst_n = 1'b0;
        bus2.out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp2_q.delete();
        exps2_q.delete();
        bus2.out_ready = 1'b1;
        chk("t6_busy",   bus2.busy, 0);
        chk("t6_update", bus2.update, 0);
        chk("t6_done",   bus2.done, 0);
        chk("t6_data",   bus2.sorted_data, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", done2_flag, 0);
        start2();
        load2(8, 200, 100, 150, 0, 1);
        wait_done2(20, 0);
        chk_seq2("t6_reload_seq", 8, 100, 150, 200);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
